rpn_tokenizer: RTL and testbench

Upstream front-end for the RPN calculator. It consumes a stream of ASCII characters, accumulates decimal digit runs into unsigned WIDTH-bit numbers, and maps operator characters to the calculator's 3-bit operator codes. It then presents one token at a time on a strobe/ack handshake that connects directly to the calculator's input port (input_stb / input_data / is_input_operator / input_ack).

---
 rtl/rpn_tokenizer.sv | 143 ++++++++++++++
 tb/tb_rpn_tokenizer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_tokenizer.sv
// rpn_tokenizer: turns an ASCII character stream into number and operator tokens
// for the RPN calculator, presenting one token at a time on a strobe/ack handshake.
`timescale 1ns/1ps
module rpn_tokenizer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             char_stb,
    input  logic [7:0]       char_data,
    output logic             char_ack,
    output logic             tok_stb,
    output logic [WIDTH-1:0] tok_data,
    output logic             tok_is_op,
    input  logic             tok_ack,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WNUM,
        S_WOP,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_haveNum;
    logic             r_pendValid;
    logic [2:0]       r_pendCode;

    logic             w_isDigit;
    logic             w_isDelim;
    logic             w_isOp;
    logic [2:0]       w_opCode;
    logic [WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0] w_opWord;
    logic [WIDTH-1:0] w_pendWord;

    // Character classification; an operator is any class with a nonzero code.
    always_comb begin
        w_isDigit = 1'b0;
        w_isDelim = 1'b0;
        w_opCode  = 3'b000;
        case (char_data)
            8'h20, 8'h0D, 8'h0A: w_isDelim = 1'b1;
            8'h2A:               w_opCode  = 3'b001;
            8'h2B:               w_opCode  = 3'b010;
            8'h2D:               w_opCode  = 3'b011;
            8'h3D:               w_opCode  = 3'b100;
            default:             w_isDigit = (char_data >= 8'h30) && (char_data <= 8'h39);
        endcase
        w_isOp = (w_opCode != 3'b000);
    end

    // Digit value is the low nibble of '0'..'9'; the multiply-add wraps silently.
    assign w_accNext  = (r_acc * WIDTH'(10)) + {{(WIDTH-4){1'b0}}, char_data[3:0]};
    assign w_opWord   = {{(WIDTH-3){1'b0}}, w_opCode};
    assign w_pendWord = {{(WIDTH-3){1'b0}}, r_pendCode};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_haveNum   <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendCode  <= 3'b000;
            char_ack    <= 1'b0;
            tok_stb     <= 1'b0;
            tok_data    <= '0;
            tok_is_op   <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (char_stb) begin
                        if (w_isDigit) begin
                            r_acc     <= w_accNext;
                            r_haveNum <= 1'b1;
                            char_ack  <= 1'b1;
                            r_state   <= S_GAP;
                        end else if ((w_isDelim || w_isOp) && r_haveNum) begin
                            // A pending number always goes out first; the operator waits behind it.
                            tok_data    <= r_acc;
                            tok_is_op   <= 1'b0;
                            tok_stb     <= 1'b1;
                            r_pendValid <= w_isOp;
                            r_pendCode  <= w_opCode;
                            r_state     <= S_WNUM;
                        end else if (w_isOp) begin
                            tok_data  <= w_opWord;
                            tok_is_op <= 1'b1;
                            tok_stb   <= 1'b1;
                            r_state   <= S_WOP;
                        end else if (w_isDelim) begin
                            char_ack <= 1'b1;
                            r_state  <= S_GAP;
                        end else begin
                            err      <= 1'b1;
                            char_ack <= 1'b1;
                            r_state  <= S_GAP;
                        end
                    end
                end

                S_WNUM: begin
                    if (tok_ack) begin
                        r_acc       <= '0;
                        r_haveNum   <= 1'b0;
                        r_pendValid <= 1'b0;
                        if (r_pendValid) begin
                            tok_data  <= w_pendWord;
                            tok_is_op <= 1'b1;
                            tok_stb   <= 1'b1;
                            r_state   <= S_WOP;
                        end else begin
                            tok_stb  <= 1'b0;
                            char_ack <= 1'b1;
                            r_state  <= S_GAP;
                        end
                    end
                end

                S_WOP: begin
                    if (tok_ack) begin
                        tok_stb   <= 1'b0;
                        tok_is_op <= 1'b0;
                        char_ack  <= 1'b1;
                        r_state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    char_ack <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_tokenizer.sv
// tb_rpn_tokenizer: table vectors, hand-written handshake corner cases and a
// randomized character stream checked against a behavioural tokenizer model.
`timescale 1ns/1ps
module tb_rpn_tokenizer;

    localparam int WIDTH = 32;

    logic             CLK = 1'b0;
    logic             RST;
    logic             char_stb;
    logic [7:0]       char_data;
    logic             char_ack;
    logic             tok_stb;
    logic [WIDTH-1:0] tok_data;
    logic             tok_is_op;
    logic             tok_ack;
    logic             err;

    int checks = 0;
    int errors = 0;

    // Tokens are stored as {is_op, data}.
    logic [WIDTH:0] gotQ[$];
    logic [WIDTH:0] expQ[$];

    logic [WIDTH-1:0] mAcc;
    bit               mHave;
    bit               mErr;

    typedef struct {
        string          text;
        int             nTok;
        logic [3:0][WIDTH:0] toks;
        logic           expErr;
    } vec_t;

    vec_t vecs[8];

    rpn_tokenizer #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .char_stb  (char_stb),
        .char_data (char_data),
        .char_ack  (char_ack),
        .tok_stb   (tok_stb),
        .tok_data  (tok_data),
        .tok_is_op (tok_is_op),
        .tok_ack   (tok_ack),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [WIDTH:0] numTok(input logic [WIDTH-1:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [WIDTH:0] opTok(input logic [2:0] c);
        return {1'b1, {(WIDTH-3){1'b0}}, c};
    endfunction

    function automatic logic [2:0] opCodeOf(input logic [7:0] c);
        case (c)
            "*":     return 3'b001;
            "+":     return 3'b010;
            "-":     return 3'b011;
            "=":     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural tokenizer: what each character should emit, from the character rules alone.
    task automatic modelChar(input logic [7:0] c);
        logic [2:0] code;
        code = opCodeOf(c);
        if (c >= "0" && c <= "9") begin
            mAcc  = mAcc * 10 + WIDTH'(c - 8'd48);
            mHave = 1'b1;
        end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
            if (mHave) expQ.push_back(numTok(mAcc));
            mAcc  = '0;
            mHave = 1'b0;
        end else if (code != 3'b000) begin
            if (mHave) expQ.push_back(numTok(mAcc));
            mAcc  = '0;
            mHave = 1'b0;
            expQ.push_back(opTok(code));
        end else begin
            mErr = 1'b1;
        end
    endtask

    task automatic doReset();
        RST       = 1'b1;
        char_stb  = 1'b0;
        char_data = 8'h00;
        tok_ack   = 1'b0;
        #1;
        checkOutput("resetOutputs", {char_ack, tok_stb, tok_is_op, err, tok_data}, 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        gotQ.delete();
        expQ.delete();
        mAcc  = '0;
        mHave = 1'b0;
        mErr  = 1'b0;
    endtask

    // Present one character, accept tokens after ackDelay cycles each, return at its char_ack.
    task automatic applyStimulus(input logic [7:0] c, input int ackDelay, output int nTok);
        int waitCnt;
        bit done;
        bit ackedLast;
        nTok    = 0;
        waitCnt = 0;
        done    = 0;
        @(negedge CLK);
        char_data = c;
        char_stb  = 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge CLK);
            #1;
            ackedLast = tok_ack;
            tok_ack   = 1'b0;
            if (ackedLast) waitCnt = 0;
            if (char_ack) begin
                done     = 1;
                char_stb = 1'b0;
            end else if (tok_stb) begin
                if (waitCnt >= ackDelay) begin
                    gotQ.push_back({tok_is_op, tok_data});
                    nTok++;
                    tok_ack = 1'b1;
                end else begin
                    waitCnt++;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL charAckTimeout: char 0x%0h got no char_ack within 200 cycles", c);
            char_stb = 1'b0;
            tok_ack  = 1'b0;
        end
    endtask

    task automatic runString(input string s, input int ackDelay);
        int n;
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], ackDelay, n);
    endtask

    task automatic waitTokStb(input string name);
        bit seen;
        seen = 0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(posedge CLK);
            #1;
            if (tok_stb) seen = 1;
        end
        checkOutput(name, 64'(seen), 64'd1);
    endtask

    task automatic setVec(input int idx, input string t, input int n,
                          input logic [WIDTH:0] t0, input logic [WIDTH:0] t1,
                          input logic [WIDTH:0] t2, input logic [WIDTH:0] t3, input logic e);
        vecs[idx].text    = t;
        vecs[idx].nTok    = n;
        vecs[idx].toks[0] = t0;
        vecs[idx].toks[1] = t1;
        vecs[idx].toks[2] = t2;
        vecs[idx].toks[3] = t3;
        vecs[idx].expErr  = e;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int nExp;
        logic [7:0] c;
        logic [WIDTH-1:0] heldData;

        setVec(0, "12 3+=",      4, numTok(12), numTok(3), opTok(3'b010), opTok(3'b100), 1'b0);
        setVec(1, "7*",          2, numTok(7), opTok(3'b001), '0, '0, 1'b0);
        setVec(2, "4294967296 ", 1, numTok(32'h0), '0, '0, '0, 1'b0);
        setVec(3, "4294967295 ", 1, numTok(32'hFFFF_FFFF), '0, '0, '0, 1'b0);
        setVec(4, "5a6 ",        1, numTok(56), '0, '0, '0, 1'b1);
        setVec(5, "3 4-=",       4, numTok(3), numTok(4), opTok(3'b011), opTok(3'b100), 1'b0);
        setVec(6, " \r\n=",      1, opTok(3'b100), '0, '0, '0, 1'b0);
        setVec(7, "/0:9\n",      1, numTok(9), '0, '0, '0, 1'b1);

        for (int v = 0; v < 8; v++) begin
            doReset();
            runString(vecs[v].text, v % 3);
            checkOutput($sformatf("vec%0d.tokCount", v), 64'(gotQ.size()), 64'(vecs[v].nTok));
            for (int t = 0; t < vecs[v].nTok && t < gotQ.size(); t++)
                checkOutput($sformatf("vec%0d.tok%0d", v, t), 64'(gotQ[t]), 64'(vecs[v].toks[t]));
            checkOutput($sformatf("vec%0d.err", v), 64'(err), 64'(vecs[v].expErr));
        end

        // "7*": number then operator with tok_stb held across the switch, one char_ack at the end.
        doReset();
        applyStimulus("7", 0, n);
        @(negedge CLK);
        char_data = "*";
        char_stb  = 1'b1;
        waitTokStb("b2b.firstStb");
        checkOutput("b2b.numTok", {31'd0, tok_is_op, tok_data}, {31'd0, numTok(7)});
        tok_ack = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("b2b.opTok", {29'd0, char_ack, tok_stb, tok_is_op, tok_data},
                    {29'd0, 1'b0, 1'b1, opTok(3'b001)});
        @(posedge CLK);
        #1;
        checkOutput("b2b.ackAfterOp", {62'd0, tok_stb, char_ack}, {62'd0, 1'b0, 1'b1});
        tok_ack  = 1'b0;
        char_stb = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("b2b.ackPulse", 64'(char_ack), 64'd0);

        // Stall: number 9 held for 5 cycles without ack.
        doReset();
        applyStimulus("9", 0, n);
        @(negedge CLK);
        char_data = " ";
        char_stb  = 1'b1;
        waitTokStb("stall.stb");
        heldData = tok_data;
        checkOutput("stall.data", 64'(heldData), 64'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            checkOutput($sformatf("stall.hold%0d", i), {30'd0, char_ack, tok_stb, tok_is_op, tok_data},
                        {30'd0, 1'b0, 1'b1, 1'b0, 32'd9});
        end
        tok_ack = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("stall.release", {62'd0, tok_stb, char_ack}, {62'd0, 1'b0, 1'b1});
        tok_ack  = 1'b0;
        char_stb = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("stall.ackPulse", 64'(char_ack), 64'd0);

        // Reset while an operator token waits for ack, with err already set.
        doReset();
        applyStimulus("x", 0, n);
        checkOutput("rst.errSet", 64'(err), 64'd1);
        @(negedge CLK);
        char_data = "+";
        char_stb  = 1'b1;
        waitTokStb("rst.opStb");
        checkOutput("rst.opTok", {31'd0, tok_is_op, tok_data}, {31'd0, opTok(3'b010)});
        doReset();
        runString("3 4-=", 1);
        checkOutput("rst.after.count", 64'(gotQ.size()), 64'd4);
        if (gotQ.size() == 4) begin
            checkOutput("rst.after.tok0", 64'(gotQ[0]), 64'(numTok(3)));
            checkOutput("rst.after.tok1", 64'(gotQ[1]), 64'(numTok(4)));
            checkOutput("rst.after.tok2", 64'(gotQ[2]), 64'(opTok(3'b011)));
            checkOutput("rst.after.tok3", 64'(gotQ[3]), 64'(opTok(3'b100)));
        end

        // Random character stream against the behavioural model.
        doReset();
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r <= 10)      c = 8'd48 + 8'($urandom_range(0, 9));
            else if (r == 11) c = 8'h20;
            else if (r == 12) c = 8'h0D;
            else if (r == 13) c = 8'h0A;
            else if (r == 14) c = "*";
            else if (r == 15) c = "+";
            else if (r == 16) c = "-";
            else if (r == 17) c = "=";
            else if (r == 18) c = (($urandom_range(0, 1) == 0) ? 8'h2F : 8'h3A);
            else              c = 8'($urandom_range(0, 255));
            gotQ.delete();
            expQ.delete();
            modelChar(c);
            nExp = expQ.size();
            applyStimulus(c, int'($urandom_range(0, 3)), n);
            checkOutput($sformatf("rand%0d.tokCount", i), 64'(n), 64'(nExp));
            for (int t = 0; t < nExp && t < gotQ.size(); t++)
                checkOutput($sformatf("rand%0d.tok%0d", i, t), 64'(gotQ[t]), 64'(expQ[t]));
            checkOutput($sformatf("rand%0d.err", i), 64'(err), 64'(mErr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
